// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the keypad scanner.
//   state_t        : scanner FSM states
//   ROWS / COLS    : keypad matrix dimensions
//   pack_key_code  : builds the 4-bit key code {row, col}
//   first_low_col  : lowest-index active-low column (column 0 has priority)
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  function automatic logic [3:0] pack_key_code(input logic [1:0] row,
                                               input logic [1:0] col);
    return {row, col};
  endfunction

  // Walk from the highest column down so the lowest low column wins.
  function automatic logic [1:0] first_low_col(input logic [COLS-1:0] cols);
    logic [1:0] idx;
    idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-output signals of the scanner, bundled together.
//   col_in    : keypad column returns, asynchronous, active-low
//   row_out   : one-cold active-low row drive
//   key_press : high while a debounced key is held
//   key_code  : {row, col} of the accepted key
// master = scanner, slave = keypad matrix / calculator front end.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [COLS-1:0] col_in;
  logic [ROWS-1:0] row_out;
  logic            key_press;
  logic [3:0]      key_code;

  modport master (
    input  col_in,
    output row_out,
    output key_press,
    output key_code
  );

  modport slave (
    output col_in,
    input  row_out,
    input  key_press,
    input  key_code
  );

endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
//   clk, rst : clock and synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output, two clocks behind d
// Both flops reset to RST_VAL so no false edge appears after reset.
module sync_2ff #(
  parameter int             WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: flops are written with non-blocking assignments so meta and q
  // both sample their inputs from before the edge, giving two real stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce.
//   clk, rst : clock and synchronous active-high reset
//   kp       : keypad_scanner_if.master (col_in, row_out, key_press, key_code)
// One row is driven low per SCAN_DIV-cycle window; at the end of the window
// the synchronized columns are checked. A low column is debounced for
// DEBOUNCE_CYCLES samples before key_press rises, and the release is
// debounced the same way before it falls.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int WIN_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SCAN_DIV - 1);

  logic [COLS-1:0]  col_s;
  state_t           state;
  logic [1:0]       row_idx;
  logic [ROWS-1:0]  row_out_q;
  logic [WIN_W-1:0] win_cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic [1:0]       cap_col;
  logic             key_press_q;
  logic [3:0]       key_code_q;
  logic             col_bit;

  sync_2ff #(
    .WIDTH   (COLS),
    .RST_VAL ({COLS{1'b1}})
  ) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (kp.col_in),
    .q   (col_s)
  );

  // Row stays frozen from capture until release, so row_idx is the
  // captured row and only the column has to be remembered.
  assign col_bit = col_s[cap_col];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      row_idx     <= '0;
      row_out_q   <= 4'b1110;
      win_cnt     <= '0;
      deb_cnt     <= '0;
      cap_col     <= '0;
      key_press_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (win_cnt == WIN_LAST) begin
            win_cnt <= '0;
            if (&col_s) begin
              row_idx   <= row_idx + 2'd1;
              row_out_q <= {row_out_q[ROWS-2:0], row_out_q[ROWS-1]};
            end else begin
              cap_col <= first_low_col(col_s);
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (!col_bit) begin
            if (int'(deb_cnt) + 1 == DEBOUNCE_CYCLES) begin
              deb_cnt     <= '0;
              key_press_q <= 1'b1;
              key_code_q  <= pack_key_code(row_idx, cap_col);
              state       <= PRESSED;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            row_idx   <= row_idx + 2'd1;
            row_out_q <= {row_out_q[ROWS-2:0], row_out_q[ROWS-1]};
            win_cnt   <= '0;
            state     <= SCAN;
          end
        end

        // The high sample that leaves PRESSED is the first of the
        // DEBOUNCE_CYCLES release samples.
        PRESSED: begin
          if (col_bit) begin
            if (DEBOUNCE_CYCLES == 1) begin
              key_press_q <= 1'b0;
              row_idx     <= row_idx + 2'd1;
              row_out_q   <= {row_out_q[ROWS-2:0], row_out_q[ROWS-1]};
              win_cnt     <= '0;
              state       <= SCAN;
            end else begin
              deb_cnt <= '0;
              state   <= RELEASE;
            end
          end
        end

        // deb_cnt + 2 = samples seen including this one and the transition.
        RELEASE: begin
          if (col_bit) begin
            if (int'(deb_cnt) + 2 >= DEBOUNCE_CYCLES) begin
              key_press_q <= 1'b0;
              row_idx     <= row_idx + 2'd1;
              row_out_q   <= {row_out_q[ROWS-2:0], row_out_q[ROWS-1]};
              win_cnt     <= '0;
              deb_cnt     <= '0;
              state       <= SCAN;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            deb_cnt <= '0;
            state   <= PRESSED;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

  assign kp.row_out   = row_out_q;
  assign kp.key_press = key_press_q;
  assign kp.key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with SCAN_DIV = 4, D = 8.
// A small keypad model pulls a column low whenever a pressed key's row is
// driven. Inputs change and outputs are sampled on the falling clock edge;
// "Pn" in comments is the n-th rising edge after reset is released.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] keys;   // bit r*4+c : key at row r, column c held down
  int          n_checks;
  int          n_err;

  logic [3:0] row_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    kp.col_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !kp.row_out[r]) kp.col_in[c] = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    keys = '0;
    rst  = 1'b1;
    cyc(2);
    check("rst_row_out", kp.row_out, 4'b1110);
    check("rst_key_press", {3'b0, kp.key_press}, 4'd0);
    check("rst_key_code", kp.key_code, 4'd0);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    keys     = '0;
    rst      = 1'b1;

    // No key: rows rotate every 4 cycles, key_press stays low.
    do_reset();
    for (int k = 0; k < 64; k++) begin
      check("idle_row_out", kp.row_out, row_pat[(k / 4) % 4]);
      check("idle_key_press", {3'b0, kp.key_press}, 4'd0);
      cyc(1);
    end

    // Clean press row 2 / col 1: capture at P12, key_press at P20.
    do_reset();
    keys = 16'h0200;
    cyc(19);
    check("press_before", {3'b0, kp.key_press}, 4'd0);
    check("press_row_frozen", kp.row_out, 4'b1011);
    cyc(1);
    check("press_rise", {3'b0, kp.key_press}, 4'd1);
    check("press_code", kp.key_code, 4'b1001);
    check("press_row_held", kp.row_out, 4'b1011);
    // Clean release: FSM sees high at P23, key_press falls at P30.
    keys = '0;
    cyc(9);
    check("release_before", {3'b0, kp.key_press}, 4'd1);
    cyc(1);
    check("release_fall", {3'b0, kp.key_press}, 4'd0);
    check("release_code_kept", kp.key_code, 4'b1001);
    check("release_next_row", kp.row_out, 4'b0111);

    // Bounce on press, row 1 / col 3: capture at P8, high seen at P11
    // aborts to row 2; re-capture at P27, key_press at P35.
    do_reset();
    keys = 16'h0080;
    cyc(8);
    check("bounce_cap_row", kp.row_out, 4'b1101);
    check("bounce_cap_kp", {3'b0, kp.key_press}, 4'd0);
    keys = '0;
    cyc(1);
    keys = 16'h0080;
    cyc(2);
    check("bounce_abort_row", kp.row_out, 4'b1011);
    check("bounce_abort_kp", {3'b0, kp.key_press}, 4'd0);
    for (int i = 12; i <= 34; i++) begin
      cyc(1);
      check("bounce_no_pulse", {3'b0, kp.key_press}, 4'd0);
      if (i == 27) check("bounce_recap_row", kp.row_out, 4'b1101);
    end
    cyc(1);
    check("bounce_press", {3'b0, kp.key_press}, 4'd1);
    check("bounce_code", kp.key_code, 4'b0111);

    // Bounce on release: col_in high 5 cycles, low 1, then high.
    keys = '0;
    for (int i = 36; i <= 50; i++) begin
      cyc(1);
      if (i == 40) keys = 16'h0080;
      if (i == 41) keys = '0;
      check("rel_bounce_held", {3'b0, kp.key_press}, 4'd1);
    end
    cyc(1);
    check("rel_bounce_fall", {3'b0, kp.key_press}, 4'd0);
    check("rel_bounce_code", kp.key_code, 4'b0111);
    check("rel_bounce_row", kp.row_out, 4'b1011);

    // Two keys in row 0 (cols 2 and 3): col 2 wins.
    do_reset();
    keys = 16'h000C;
    cyc(11);
    check("two_before", {3'b0, kp.key_press}, 4'd0);
    cyc(1);
    check("two_press", {3'b0, kp.key_press}, 4'd1);
    check("two_code", kp.key_code, 4'b0010);
    check("two_row", kp.row_out, 4'b1110);
    keys = 16'h0004;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      check("two_col3_released", {3'b0, kp.key_press}, 4'd1);
    end

    // Reset mid-PRESSED with col 2 still held.
    rst = 1'b1;
    cyc(1);
    check("rst_pressed_kp", {3'b0, kp.key_press}, 4'd0);
    check("rst_pressed_code", kp.key_code, 4'd0);
    check("rst_pressed_row", kp.row_out, 4'b1110);
    rst = 1'b0;
    // Re-detected from row 0; at P6 the FSM is in DEBOUNCE.
    cyc(6);
    check("redet_debounce_kp", {3'b0, kp.key_press}, 4'd0);
    check("redet_debounce_row", kp.row_out, 4'b1110);
    // Reset mid-DEBOUNCE.
    rst = 1'b1;
    cyc(1);
    check("rst_debounce_kp", {3'b0, kp.key_press}, 4'd0);
    check("rst_debounce_code", kp.key_code, 4'd0);
    check("rst_debounce_row", kp.row_out, 4'b1110);
    rst = 1'b0;
    cyc(11);
    check("redet_before", {3'b0, kp.key_press}, 4'd0);
    cyc(1);
    check("redet_press", {3'b0, kp.key_press}, 4'd1);
    check("redet_code", kp.key_code, 4'b0010);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad for the calculator front end. It drives one row low at a time, synchronizes and debounces the column returns, and produces a level `key_press` plus a 4-bit `key_code`. `key_press` is high while one debounced key is held. Its outputs feed the calculator's rising-edge key detector, which turns each press into a single-cycle pulse.

## Interface
- `SCAN_DIV`, default 50000: cycles each row is driven before its columns are sampled; must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples needed to accept a press or a release; must be ≥ 1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `col_in`  in  4  keypad columns, asynchronous, active-low (pulled up externally).
- `row_out`  out  4  row drive, one-cold, active-low.
- `key_press`  out  1  high while a debounced key is held.
- `key_code`  out  4  `{row[1:0], col[1:0]}` of the accepted key; valid while `key_press` is high.

## Operation
- `col_in` passes through a 2-flop synchronizer, giving `col_s`. Both flops reset to 4'b1111. All decisions below use `col_s`.
- Reset values:
  - `row_out` = 4'b1110
  - `key_press` = 0
  - `key_code` = 0
  - state = SCAN
  - row index = 0; window counter = 0; debounce counter = 0
- **SCAN**
  - The window counter counts 0..SCAN_DIV-1 on the current row.
  - At the last window cycle (counter = SCAN_DIV-1), `col_s` is checked:
    - All ones: row index advances 0→1→2→3→0. `row_out` rotates 1110→1101→1011→0111→1110. Counter returns to 0.
    - Any bit low: capture the row and the lowest-index low column (column priority 0>1>2>3). Go to DEBOUNCE. Debounce counter = 0. `row_out` freezes.
- **DEBOUNCE**
  - Each cycle, sample the captured column bit of `col_s`.
  - Low: increment the counter. When it reaches DEBOUNCE_CYCLES, go to PRESSED, set `key_press` to 1, and load `key_code`.
  - High: go to SCAN on the next row, with window counter = 0.
- **PRESSED**
  - `row_out` stays frozen; `key_press` stays 1; `key_code` is stable.
  - When the captured column bit goes high: go to RELEASE, debounce counter = 0.
- **RELEASE**
  - Captured bit high: increment the counter. When it reaches DEBOUNCE_CYCLES, clear `key_press` to 0, go to SCAN on the next row, window counter = 0.
  - Captured bit low: return to PRESSED, counter = 0. `key_press` stays 1.
- Other keys:
  - Columns other than the captured one are ignored from DEBOUNCE through RELEASE.
  - A second key in the same row does not affect the held key.
  - After release, scanning continues and picks up any key still held.
- `key_code` keeps its last value after release and changes only when a new press is accepted.
- `rst` asserted in any state returns every register to its reset value on that edge. A held key is then re-detected from row 0.

## Timing
- Synchronizer latency: 2 cycles from a `col_in` change to `col_s`.
- Let E be the capture edge (SCAN→DEBOUNCE) and D = DEBOUNCE_CYCLES. With a clean key, `key_press` and `key_code` are registered on edge E+D and are visible in the cycle after it.
- A key seen high at edge E+k (1 ≤ k ≤ D) returns to SCAN at that edge. `key_press` never pulses.
- With a clean release, `key_press` falls D edges after the first high sample in PRESSED, counted as the PRESSED→RELEASE transition edge plus D−1 further edges.
- Worst-case detection: 4·SCAN_DIV + D + 2 cycles after a clean press.
- Per row window, `row_out` changes exactly once, on the edge where the window counter wraps.

## Structure
- Package `keypad_pkg`:
  - state enum {SCAN, DEBOUNCE, PRESSED, RELEASE}
  - constants ROWS = 4, COLS = 4
  - the `key_code` packing function
- Counter widths are $clog2(SCAN_DIV) and $clog2(DEBOUNCE_CYCLES+1).
- Sub-module `sync_2ff`: parameterized width with a reset value, instantiated once for `col_in`.

## Test plan
All scenarios use SCAN_DIV = 4 and D = 8.
- No key: reset, then `col_in` = 1111 for 64 cycles → `row_out` cycles 1110, 1101, 1011, 0111, 4 cycles each; `key_press` stays 0.
- Clean press of row 2 / col 1:
  - `col_in` = 1101 only while `row_out` = 1011 → `key_press` rises D edges after capture with `key_code` = 4'b1001.
  - Release → `key_press` falls after 8 high samples.
- Bounce on press: `col_in` toggles low 3 cycles, high 1 cycle, then stays low → the first attempt aborts to SCAN with no pulse; the second attempt asserts `key_press`.
- Bounce on release: high for 5 cycles, low for 1, then high → `key_press` stays 1 through the glitch and falls 8 samples after the final high begins.
- Two keys: row 0 cols 2 and 3 pressed together → `key_code` = 4'b0010. Releasing col 3 only leaves `key_press` at 1.
- Reset mid-DEBOUNCE and mid-PRESSED → on the next edge `key_press` = 0, `key_code` = 0, `row_out` = 1110, and the held key is re-detected from row 0.
